// File: rtl/grf_wb_pkg.sv
// grf_wb_pkg: shared constants and types for the GRF writeback arbiter.
//   AW_DEF / DW_DEF     : default register-address and data/pc widths
//   REQ_ALU/MEM/LINK    : requester slot indices on the packed request buses
//   wb_req_t            : one writeback request {addr, data, pc} at default widths
package grf_wb_pkg;
  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;

  localparam int REQ_ALU  = 0;
  localparam int REQ_MEM  = 1;
  localparam int REQ_LINK = 2;

  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
    logic [DW_DEF-1:0] pc;
  } wb_req_t;
endpackage

// File: rtl/grf_wb_arbiter_rr.sv
// rr_arbiter: combinational rotate-priority arbiter.
//   req   in  N   request vector
//   ptr   in  IW  highest-priority index this cycle (must be < N)
//   en    in  1   grant enable; all-zero grant when low
//   grant out N   one-hot grant (zero if none)
//   idx   out IW  encoded index of the granted bit
//   any   out 1   a grant was issued
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] w_j;

  // Scan ptr, ptr+1, ... wrapping; first requester seen wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    w_j   = '0;
    for (int k = 0; k < N; k++) begin
      w_j = IW'((int'(ptr) + k) % N);
      if (en && !any && req[w_j]) begin
        any        = 1'b1;
        grant[w_j] = 1'b1;
        idx        = w_j;
      end
    end
  end
endmodule

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: shares the single GRF write port between NREQ writeback
// requesters with a round-robin valid/ready grant; one registered write per
// cycle; flags same-cycle writes from different requesters to one nonzero reg.
//   clk, reset_n           clock (rising) / async active-low reset
//   hold                   pipeline freeze, suppresses all grants
//   req_valid/req_ready    per-requester handshake (ready is one-hot)
//   req_addr/data/pc       packed request fields, requester i at [i*W +: W]
//   grf_we/a3/wd/pc        registered GRF write port
//   conflict               registered diagnostic pulse
// Optional macro GRF_WB_TRACE_EN: simulation trace line per transfer.
module grf_wb_arbiter
  import grf_wb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               hold,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ*DW-1:0] req_pc,
  output logic               grf_we,
  output logic [AW-1:0]      grf_a3,
  output logic [DW-1:0]      grf_wd,
  output logic [DW-1:0]      grf_pc,
  output logic               conflict
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0][AW-1:0] w_addr;
  logic [NREQ-1:0][DW-1:0] w_data;
  logic [NREQ-1:0][DW-1:0] w_pc;
  logic [NREQ-1:0]         w_grant;
  logic [IW-1:0]           w_idx;
  logic                    w_xfer;
  logic                    w_conflict;
  logic [IW-1:0]           w_ptr_nxt;

  logic [IW-1:0] r_ptr;
  logic          r_we;
  logic [AW-1:0] r_a3;
  logic [DW-1:0] r_wd;
  logic [DW-1:0] r_pc;
  logic          r_conflict;

  assign w_addr = req_addr;
  assign w_data = req_data;
  assign w_pc   = req_pc;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
    .req   (req_valid),
    .ptr   (r_ptr),
    .en    (!hold),
    .grant (w_grant),
    .idx   (w_idx),
    .any   (w_xfer)
  );

  // The grant only ever selects a valid requester, so any grant is a transfer.
  assign req_ready = w_grant;

  assign w_ptr_nxt = (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + IW'(1);

  // Pairwise compare; address 0 is never a real destination. hold ignored.
  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < NREQ; i++)
      for (int j = i + 1; j < NREQ; j++)
        if (req_valid[i] && req_valid[j] && (w_addr[i] == w_addr[j]) && (|w_addr[i]))
          w_conflict = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr      <= '0;
      r_we       <= 1'b0;
      r_a3       <= '0;
      r_wd       <= '0;
      r_pc       <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_we       <= w_xfer;
      r_conflict <= w_conflict;
      if (w_xfer) begin
        r_ptr <= w_ptr_nxt;
        r_a3  <= w_addr[w_idx];
        r_wd  <= w_data[w_idx];
        r_pc  <= w_pc[w_idx];
      end
    end
  end

  assign grf_we   = r_we;
  assign grf_a3   = r_a3;
  assign grf_wd   = r_wd;
  assign grf_pc   = r_pc;
  assign conflict = r_conflict;

`ifdef GRF_WB_TRACE_EN
  always @(posedge clk) begin
    if (reset_n && w_xfer)
      $display("%d@%h: $%d <= %h", $time, w_pc[w_idx], w_addr[w_idx], w_data[w_idx]);
  end
`else
`endif
endmodule
